// File: rtl/cpu_pkg.sv
// Shared definitions for the scalar CPU and tensor-core datapath:
// opcodes, bus width, status-bit positions and a parity helper.
package cpu_pkg;

  localparam int BUS_WIDTH = 8;

  localparam logic [7:0] ADD_OPCODE              = 8'h00;
  localparam logic [7:0] SUB_OPCODE              = 8'h01;
  localparam logic [7:0] MUL_OPCODE              = 8'h02;
  localparam logic [7:0] EQL_OPCODE              = 8'h03;
  localparam logic [7:0] GRT_OPCODE              = 8'h04;
  localparam logic [7:0] LOAD_TENSOR_OPCODE      = 8'h05;
  localparam logic [7:0] STORE_TENSOR_OPCODE     = 8'h06;
  localparam logic [7:0] MATMUL_TENSOR_OPCODE    = 8'h07;
  localparam logic [7:0] NOP_TENSOR_OPCODE       = 8'h08;
  localparam logic [7:0] ADD_IMM_OPCODE          = 8'h09;
  localparam logic [7:0] SUB_IMM_OPCODE          = 8'h0A;
  localparam logic [7:0] MOV_OPCODE              = 8'h0B;
  localparam logic [7:0] RESET_TENSOR_OPCODE     = 8'h0C;
  localparam logic [7:0] RESET_OPCODE            = 8'h0D;
  localparam logic [7:0] STATUS_TENSOR_OPCODE    = 8'h0E;
  localparam logic [7:0] READ_CPU_OPCODE         = 8'h0F;
  localparam logic [7:0] READ_TENSOR_CORE_OPCODE = 8'h10;

  localparam int STATUS_PARITY   = 4;
  localparam int STATUS_OVERFLOW = 3;
  localparam int STATUS_CARRY    = 2;
  localparam int STATUS_ZERO     = 1;
  localparam int STATUS_SIGN     = 0;

  // 1 when the operand holds an even number of ones.
  function automatic logic even_parity(input logic [BUS_WIDTH-1:0] value);
    return ~(^value);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit signed ALU producing a result and five status flags.
// A disabled or reset ALU drives zero on every output.
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = BUS_WIDTH
) (
  input  logic                     reset_in,
  input  logic                     enable_in,
  input  logic [7:0]               opcode_in,
  input  logic signed [DATA_W-1:0] alu_input1,
  input  logic signed [DATA_W-1:0] alu_input2,
  output logic signed [DATA_W-1:0] alu_output,
  output logic                     parity_out,
  output logic                     overflow_out,
  output logic                     carry_out,
  output logic                     zero_out,
  output logic                     sign_out
);

  logic [DATA_W-1:0]          w_result;
  logic [DATA_W:0]            w_wide;
  logic signed [2*DATA_W-1:0] w_prod;
  logic                       w_carry;
  logic                       w_ovf;
  logic                       w_active;

  // Operation select and per-opcode carry/overflow rules.
  always_comb begin
    w_result = '0;
    w_wide   = '0;
    w_prod   = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    w_active = 1'b0;
    if (reset_in || !enable_in) begin
      w_active = 1'b0;
    end else begin
      case (opcode_in)
        ADD_OPCODE, ADD_IMM_OPCODE: begin
          w_active = 1'b1;
          w_wide   = {1'b0, alu_input1} + {1'b0, alu_input2};
          w_result = w_wide[DATA_W-1:0];
          w_carry  = w_wide[DATA_W];
          w_ovf    = (alu_input1[DATA_W-1] == alu_input2[DATA_W-1]) &&
                     (w_result[DATA_W-1] != alu_input1[DATA_W-1]);
        end
        SUB_OPCODE, SUB_IMM_OPCODE: begin
          // The ninth bit of the zero-extended difference is the unsigned borrow.
          w_active = 1'b1;
          w_wide   = {1'b0, alu_input1} - {1'b0, alu_input2};
          w_result = w_wide[DATA_W-1:0];
          w_carry  = w_wide[DATA_W];
          w_ovf    = (alu_input1[DATA_W-1] != alu_input2[DATA_W-1]) &&
                     (w_result[DATA_W-1] != alu_input1[DATA_W-1]);
        end
        MUL_OPCODE: begin
          w_active = 1'b1;
          w_prod   = (2*DATA_W)'(alu_input1) * (2*DATA_W)'(alu_input2);
          w_result = w_prod[DATA_W-1:0];
          w_ovf    = (w_prod != {{DATA_W{w_prod[DATA_W-1]}}, w_prod[DATA_W-1:0]});
          w_carry  = w_ovf;
        end
        EQL_OPCODE: begin
          w_active = 1'b1;
          w_result = (alu_input1 == alu_input2) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
        end
        GRT_OPCODE: begin
          w_active = 1'b1;
          w_result = (alu_input1 > alu_input2) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
        end
        MOV_OPCODE: begin
          w_active = 1'b1;
          w_result = alu_input1;
        end
        default: begin
          w_active = 1'b0;
        end
      endcase
    end
  end

  assign alu_output   = w_result;
  assign carry_out    = w_carry;
  assign overflow_out = w_ovf;
  assign zero_out     = w_active && (w_result == '0);
  assign sign_out     = w_active && w_result[DATA_W-1];
  assign parity_out   = w_active && even_parity(w_result);

endmodule

// File: rtl/cpu_register_file.sv
// Register file with two combinational read ports, one synchronous write
// port and a synchronous clear that overrides the write.
module cpu_register_file
  import cpu_pkg::*;
#(
  parameter int DATA_W   = BUS_WIDTH,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              write_enable_in,
  input  logic [ADDR_W-1:0] read_addr1_in,
  input  logic [ADDR_W-1:0] read_addr2_in,
  input  logic [ADDR_W-1:0] write_addr_in,
  input  logic [DATA_W-1:0] write_data_in,
  output logic [DATA_W-1:0] read_data1_out,
  output logic [DATA_W-1:0] read_data2_out
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // Clear-or-write storage update.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (write_enable_in) begin
      r_regs[write_addr_in] <= write_data_in;
    end else begin
      r_regs[write_addr_in] <= r_regs[write_addr_in];
    end
  end

  assign read_data1_out = r_regs[read_addr1_in];
  assign read_data2_out = r_regs[read_addr2_in];

endmodule

// File: rtl/cpu_alu_regfile.sv
// Scalar execute stage: decodes one instruction per cycle, runs the ALU on
// register/immediate operands and writes the result and status flags back.
module cpu_alu_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W   = BUS_WIDTH,
  parameter int NUM_REGS = 32
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic [31:0]       current_instruction,
  output logic [DATA_W-1:0] cpu_output,
  output logic [4:0]        status_out
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [7:0]        w_opcode;
  logic [ADDR_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_rs1;
  logic [ADDR_W-1:0] w_rs2;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_reg_b;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_alu_out;
  logic [4:0]        w_flags;
  logic              w_write_en;
  logic              w_use_imm;
  logic              w_clear;
  logic [4:0]        r_status;

  assign w_opcode = current_instruction[7:0];
  assign w_rd     = current_instruction[24 +: ADDR_W];
  assign w_rs1    = current_instruction[16 +: ADDR_W];
  assign w_rs2    = current_instruction[8 +: ADDR_W];
  assign w_imm    = DATA_W'(signed'(current_instruction[15:8]));

  // Instruction decode: write enable, immediate select and clear request.
  always_comb begin
    w_write_en = 1'b0;
    w_use_imm  = 1'b0;
    w_clear    = reset_in;
    case (w_opcode)
      ADD_OPCODE, SUB_OPCODE, MUL_OPCODE, EQL_OPCODE, GRT_OPCODE, MOV_OPCODE: begin
        w_write_en = 1'b1;
      end
      ADD_IMM_OPCODE, SUB_IMM_OPCODE: begin
        w_write_en = 1'b1;
        w_use_imm  = 1'b1;
      end
      RESET_OPCODE: begin
        w_clear = 1'b1;
      end
      default: begin
        w_write_en = 1'b0;
      end
    endcase
  end

  assign w_op_b = w_use_imm ? w_imm : w_reg_b;

  cpu_register_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_regfile (
    .clock_in        (clock_in),
    .reset_in        (w_clear),
    .write_enable_in (w_write_en),
    .read_addr1_in   (w_rs1),
    .read_addr2_in   (w_rs2),
    .write_addr_in   (w_rd),
    .write_data_in   (w_alu_out),
    .read_data1_out  (w_op_a),
    .read_data2_out  (w_reg_b)
  );

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .reset_in     (w_clear),
    .enable_in    (w_write_en),
    .opcode_in    (w_opcode),
    .alu_input1   (w_op_a),
    .alu_input2   (w_op_b),
    .alu_output   (w_alu_out),
    .parity_out   (w_flags[STATUS_PARITY]),
    .overflow_out (w_flags[STATUS_OVERFLOW]),
    .carry_out    (w_flags[STATUS_CARRY]),
    .zero_out     (w_flags[STATUS_ZERO]),
    .sign_out     (w_flags[STATUS_SIGN])
  );

  // Status register: cleared with the register file, loaded only on write-back.
  always_ff @(posedge clock_in) begin
    if (w_clear) begin
      r_status <= 5'd0;
    end else if (w_write_en) begin
      r_status <= w_flags;
    end else begin
      r_status <= r_status;
    end
  end

  assign status_out = r_status;

  // Output mux: READ_CPU exposes operand A, reset forces zero.
  always_comb begin
    cpu_output = w_alu_out;
    if (reset_in) begin
      cpu_output = '0;
    end else if (w_opcode == READ_CPU_OPCODE) begin
      cpu_output = w_op_a;
    end else begin
      cpu_output = w_alu_out;
    end
  end

endmodule

// File: tb/tb_cpu_alu_regfile.sv
// Self-checking bench for cpu_alu_regfile: directed test-plan steps followed
// by random instructions, all compared against an integer reference model.
module tb_cpu_alu_regfile;

  logic        clock_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [31:0] current_instruction = 32'd0;
  logic [7:0]  cpu_output;
  logic [4:0]  status_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_regs [32];
  logic [4:0] m_status = 5'd0;
  logic [7:0] obs_out;
  logic [4:0] saved_status;

  always #5 clock_in = ~clock_in;

  cpu_alu_regfile dut (
    .clock_in            (clock_in),
    .reset_in            (reset_in),
    .current_instruction (current_instruction),
    .cpu_output          (cpu_output),
    .status_out          (status_out)
  );

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] rd,
                                     input logic [7:0] rs1, input logic [7:0] rs2);
    return {rd, rs1, rs2, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: integer arithmetic on the architectural rules.
  task automatic model_exec(input logic [31:0] ins, output logic [7:0] r,
                            output logic [4:0] f, output bit wr, output bit clr);
    int a, b, s;
    int unsigned ua, ub;
    bit c, v, imm;
    logic [7:0] op;
    op  = ins[7:0];
    imm = (op == 8'h09) || (op == 8'h0A);
    a   = $signed(m_regs[ins[20:16]]);
    b   = imm ? $signed(ins[15:8]) : $signed(m_regs[ins[12:8]]);
    ua  = a & 255;
    ub  = b & 255;
    c = 1'b0; v = 1'b0; wr = 1'b1; clr = 1'b0; s = 0;
    case (op)
      8'h00, 8'h09: begin s = a + b; c = (ua + ub) > 255; v = (s > 127) || (s < -128); end
      8'h01, 8'h0A: begin s = a - b; c = ua < ub; v = (s > 127) || (s < -128); end
      8'h02: begin s = a * b; v = (s > 127) || (s < -128); c = v; end
      8'h03: s = (a == b) ? 1 : 0;
      8'h04: s = (a > b) ? 1 : 0;
      8'h0B: s = a;
      8'h0D: begin wr = 1'b0; clr = 1'b1; end
      default: wr = 1'b0;
    endcase
    r = s[7:0];
    f = {($countones(r) % 2) == 0, v, c, r == 8'd0, r[7]};
  endtask

  task automatic step(input logic [31:0] ins, input logic rst);
    logic [7:0] r, a, exp_out;
    logic [4:0] f;
    bit wr, clr;
    @(negedge clock_in);
    reset_in = rst;
    current_instruction = ins;
    #1;
    model_exec(ins, r, f, wr, clr);
    a = m_regs[ins[20:16]];
    if (rst) exp_out = 8'd0;
    else if (ins[7:0] == 8'h0F) exp_out = a;
    else if (wr) exp_out = r;
    else exp_out = 8'd0;
    obs_out = cpu_output;
    check($sformatf("cpu_output op=%02h", ins[7:0]), {24'd0, cpu_output}, {24'd0, exp_out});
    @(posedge clock_in);
    if (rst || clr) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 8'd0;
      m_status = 5'd0;
    end else if (wr) begin
      m_regs[ins[28:24]] = r;
      m_status = f;
    end
    #1;
    check($sformatf("status_out op=%02h", ins[7:0]), {27'd0, status_out}, {27'd0, m_status});
  endtask

  initial begin
    logic [7:0] ops [12];
    logic [7:0] op;
    for (int i = 0; i < 32; i++) m_regs[i] = 8'd0;
    ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h09, 8'h0A, 8'h0B,
            8'h0F, 8'h08, 8'h10, 8'h55};

    // Reset, then every register reads zero.
    step(mk(8'h0F, 8'd0, 8'd3, 8'd0), 1'b1);
    step(mk(8'h09, 8'd1, 8'd0, 8'd9), 1'b1);
    check("reset_status", {27'd0, status_out}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      step(mk(8'h0F, 8'd0, 8'(i), 8'd0), 1'b0);
      check($sformatf("reset_r%0d", i), {24'd0, obs_out}, 32'd0);
    end

    // ADD overflow into the sign bit.
    step(mk(8'h09, 8'd1, 8'd0, 8'h05), 1'b0);
    step(mk(8'h09, 8'd2, 8'd0, 8'h7F), 1'b0);
    step(mk(8'h00, 8'd3, 8'd1, 8'd2), 1'b0);
    check("add_flags", {27'd0, status_out}, {27'd0, 5'b11001});
    step(mk(8'h0F, 8'd0, 8'd3, 8'd0), 1'b0);
    check("add_r3", {24'd0, obs_out}, 32'h84);

    // SUB to zero and SUB_IMM borrow.
    step(mk(8'h01, 8'd4, 8'd1, 8'd1), 1'b0);
    check("sub_zero", {27'd0, status_out}, {27'd0, 5'b10010});
    step(mk(8'h0A, 8'd5, 8'd0, 8'h01), 1'b0);
    check("subi_val", {24'd0, obs_out}, 32'hFF);
    check("subi_flags", {30'd0, status_out[2], status_out[0]}, 32'd3);

    // MUL in and out of range.
    step(mk(8'h09, 8'd6, 8'd0, 8'hFD), 1'b0);
    step(mk(8'h02, 8'd9, 8'd1, 8'd6), 1'b0);
    check("mul_neg", {24'd0, obs_out}, 32'hF1);
    check("mul_neg_ovf", {31'd0, status_out[3]}, 32'd0);
    step(mk(8'h09, 8'd10, 8'd0, 8'h10), 1'b0);
    step(mk(8'h02, 8'd11, 8'd10, 8'd10), 1'b0);
    check("mul_ovf_flags", {27'd0, status_out}, {27'd0, 5'b11110});

    // Compare, NOP and move.
    step(mk(8'h03, 8'd12, 8'd1, 8'd1), 1'b0);
    check("eql", {24'd0, obs_out}, 32'd1);
    saved_status = status_out;
    step(mk(8'h08, 8'd12, 8'd1, 8'd1), 1'b0);
    check("nop_hold", {27'd0, status_out}, {27'd0, saved_status});
    step(mk(8'h04, 8'd13, 8'd5, 8'd1), 1'b0);
    check("grt_signed", {24'd0, obs_out}, 32'd0);
    step(mk(8'h0B, 8'd7, 8'd1, 8'd0), 1'b0);
    check("mov", {24'd0, obs_out}, 32'd5);

    // Same-cycle read of the written register sees the old value.
    step(mk(8'h09, 8'd8, 8'd0, 8'h22), 1'b0);
    step(mk(8'h00, 8'd8, 8'd8, 8'd1), 1'b0);
    check("no_bypass", {24'd0, obs_out}, 32'h27);
    step(mk(8'h0F, 8'd0, 8'd8, 8'd0), 1'b0);
    check("r8_new", {24'd0, obs_out}, 32'h27);

    // RESET opcode clears everything.
    step(mk(8'h0D, 8'd1, 8'd1, 8'd1), 1'b0);
    step(mk(8'h0F, 8'd0, 8'd1, 8'd0), 1'b0);
    check("reset_op_r1", {24'd0, obs_out}, 32'd0);
    check("reset_op_status", {27'd0, status_out}, 32'd0);

    // Random instruction mix.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) op = 8'h0D;
      else op = ops[$urandom_range(0, 11)];
      step(mk(op, 8'($urandom), 8'($urandom), 8'($urandom)), $urandom_range(0, 79) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_alu_regfile.md
# cpu_alu_regfile

Scalar execute stage of the CPU. It decodes one 32-bit instruction per cycle. It reads two operands from a 32-entry, 8-bit signed register file and computes an ALU result with five status flags. It writes the result back on the next rising clock edge. It sits beside the tensor-core datapath and supplies the value driven on `cpu_output`.

## Interface
Parameters:
- `DATA_W`, default 8: register and ALU data width (signed two's complement).
- `NUM_REGS`, default 32: register-file depth; addresses are 5 bits.

Ports:
- `clock_in`  in  1: the only clock; all state updates on its rising edge.
- `reset_in`  in  1: reset is synchronous and active-high.
- `current_instruction`  in  32: bits [31:24] rd, [23:16] rs1, [15:8] rs2 or imm8, [7:0] opcode. The register address is the low 5 bits of each field.
- `cpu_output`  out  8: combinational result of the current instruction.
- `status_out`  out  5: registered flags; [4] parity, [3] overflow, [2] carry, [1] zero, [0] sign.

## Operation
Opcodes are 8-bit. A = reg[rs1]. B = reg[rs2], or imm8 (signed) for immediate ops.

- 0x00 ADD: A+B.
- 0x01 SUB: A−B.
- 0x02 MUL: low 8 bits of the signed 16-bit product A×B.
- 0x03 EQL: 1 if A==B, else 0.
- 0x04 GRT: 1 if A>B (signed), else 0.
- 0x09 ADD_IMM: A+imm8.
- 0x0A SUB_IMM: A−imm8.
- 0x0B MOV: A.
- 0x0D RESET: ALU output is 0, all flags are 0, and the register file clears on the next edge.
- 0x0F READ_CPU: `cpu_output` = A. No write.
- Any other opcode: ALU output 0, flags 0, no register write.

Write-back:
- Write enable is asserted for 0x00–0x04, 0x09, 0x0A and 0x0B only.
- reg[rd] receives the ALU output.
- `status_out` loads the ALU flags on the same edge. Otherwise it holds.

Flags are computed from the 8-bit result R:
- zero = (R==0).
- sign = R[7].
- parity = 1 when R has an even number of ones.
- ADD/ADD_IMM: carry = unsigned carry out of bit 7; overflow = signed overflow.
- SUB/SUB_IMM: carry = unsigned borrow (A<B unsigned); overflow = signed overflow.
- MUL: carry = overflow = 1 when the 16-bit signed product is not representable in 8 signed bits.
- EQL, GRT, MOV: carry = overflow = 0.

Output mux: `cpu_output` is A for READ_CPU, else the ALU output.

## Timing
- Reads are combinational from the register array; `cpu_output` is valid in the same cycle as the instruction.
- A write lands at the rising edge that ends the instruction's cycle. A read of the same register in that cycle returns the old value; there is no bypass.
- Reset: when `reset_in`=1 at a rising edge, or the opcode is RESET:
  - All 32 registers and `status_out` become 0.
  - Reset overrides any simultaneous write.
- While `reset_in`=1, `cpu_output` = 0.
- Reset value of every output is 0.
- Arithmetic wraps modulo 256; there is no saturation.
- Register 0 is an ordinary writable register.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants (ADD_OPCODE…READ_TENSOR_CORE_OPCODE, including tensor-core codes 0x05–0x08, 0x0C, 0x0E, 0x10, which this block treats as no-write).
  - `BUS_WIDTH`.
  - Status-bit index constants.
- Sub-modules:
  - `alu`: purely combinational. Ports `reset_in`, `enable_in`, `opcode_in`, `alu_input1`, `alu_input2`, `alu_output`, and five flag outputs. `enable_in`=0 forces output and flags to 0.
  - `cpu_register_file`: ports `clock_in`, `reset_in`, `write_enable_in`, two read addresses, write address, write data, and two read-data outputs.
- The top handles decode, the immediate mux and the status register.

## Test plan
- Reset, then READ_CPU of r0…r31 → `cpu_output` = 0 for every register; `status_out` = 0.
- ADD_IMM r1=r0+5, then ADD_IMM r2=r0+0x7F, then ADD r3=r1+r2 → r3 reads 0x84, overflow=1, sign=1, carry=0, zero=0, parity=1.
- SUB r4=r1−r1 → r4 = 0, zero=1, carry=0. SUB_IMM r5=r0−1 → r5 = 0xFF, carry=1, sign=1.
- MUL with r1=5, r6=−3 → 0xF1 (−15), overflow=0. MUL with 16×16 → 0x00, overflow=1, carry=1, zero=1.
- EQL r1,r1 → 1; GRT of −1 versus 5 → 0 (signed); MOV r7=r1 → r7 = 5. A NOP (0x08) between them leaves registers and `status_out` unchanged.
- Write r8 and read r8 in the same cycle → old value; next cycle → new value. RESET opcode mid-sequence → all registers read 0 next cycle.
